// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back / memory-access stage: opcodes, the
// state encoding and the datapath widths.
package wb_stage_pkg;
   localparam int DATA_W   = 32;
   localparam int REGADR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_WRITE    = 2'd2
   } state_e;

   function automatic logic is_load_op(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store_op(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction
endpackage

// File: rtl/wb_stage_if.sv
// Data-memory req/ack bus between the write-back stage (master) and memory.
interface wb_stage_if;
   import wb_stage_pkg::*;

   logic              MemReq;
   logic              MemWe;
   logic [DATA_W-1:0] MemAdr;
   logic [DATA_W-1:0] MemWdata;
   logic [3:0]        MemBe;
   logic              MemAck;
   logic [DATA_W-1:0] MemRdata;

   modport master (output MemReq, MemWe, MemAdr, MemWdata, MemBe,
                   input  MemAck, MemRdata);
   modport slave  (input  MemReq, MemWe, MemAdr, MemWdata, MemBe,
                   output MemAck, MemRdata);
endinterface

// File: rtl/wb_stage_load_align.sv
// Picks the addressed byte/halfword out of a little-endian load word and
// sign- or zero-extends it according to the load opcode.
module wb_stage_load_align
   import wb_stage_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        lane,
   input  logic [5:0]        opcode,
   output logic [DATA_W-1:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (lane)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      data = rdata;
      case (opcode)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'h000000, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// Write-back / memory-access stage: performs loads and stores over the req/ack
// bus and produces the register-file write triple (Wdata, Wadr, Wen).
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                InValid,
   output logic                InReady,
   input  logic [5:0]          Opcode,
   input  logic [5:0]          Funct,
   input  logic [REGADR_W-1:0] DstAdr,
   input  logic [DATA_W-1:0]   AluResult,
   input  logic [DATA_W-1:0]   StoreData,
   input  logic [DATA_W-1:0]   Pc4,
   wb_stage_if.master          mem,
   output logic [DATA_W-1:0]   Wdata,
   output logic [REGADR_W-1:0] Wadr,
   output logic                Wen,
   output logic                AlignExc
);
   state_e                state_q, state_d;
   logic [5:0]            opcode_q, opcode_d;
   logic [1:0]            lane_q, lane_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     adr_q, adr_d;
   logic [DATA_W-1:0]     mwdata_q, mwdata_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [REGADR_W-1:0]   wadr_q, wadr_d;
   logic                  wen_q, wen_d;
   logic                  align_exc_q, align_exc_d;
   logic [DATA_W-1:0]     load_data;
   logic                  is_ld, is_st, misaligned, alu_write;

   wb_stage_load_align u_load_align (
      .rdata  (mem.MemRdata),
      .lane   (lane_q),
      .opcode (opcode_q),
      .data   (load_data)
   );

   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      lane_d      = lane_q;
      we_d        = we_q;
      adr_d       = adr_q;
      mwdata_d    = mwdata_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      wadr_d      = wadr_q;
      wen_d       = wen_q;
      align_exc_d = 1'b0;

      is_ld      = is_load_op(Opcode);
      is_st      = is_store_op(Opcode);
      misaligned = (((Opcode == OP_LH) || (Opcode == OP_LHU) || (Opcode == OP_SH)) && AluResult[0]) ||
                   (((Opcode == OP_LW) || (Opcode == OP_SW)) && (AluResult[1:0] != 2'b00));
      // I-type ALU ops occupy opcodes 08h..0Fh.
      alu_write  = ((Opcode == OP_RTYPE) && (Funct != FN_JR)) || (Opcode[5:3] == 3'b001);

      case (state_q)
         ST_IDLE: begin
            if (InValid) begin
               if ((is_ld || is_st) && misaligned) begin
                  align_exc_d = 1'b1;
               end else if (is_ld || is_st) begin
                  state_d  = ST_MEM_WAIT;
                  opcode_d = Opcode;
                  lane_d   = AluResult[1:0];
                  we_d     = is_st;
                  adr_d    = {AluResult[31:2], 2'b00};
                  wadr_d   = DstAdr;
                  wen_d    = (DstAdr != '0);
                  be_d     = 4'b1111;
                  mwdata_d = '0;
                  case (Opcode)
                     OP_SB: begin
                        be_d     = 4'b0001 << AluResult[1:0];
                        mwdata_d = {4{StoreData[7:0]}};
                     end
                     OP_SH: begin
                        be_d     = AluResult[1] ? 4'b1100 : 4'b0011;
                        mwdata_d = {2{StoreData[15:0]}};
                     end
                     OP_SW:   mwdata_d = StoreData;
                     default: mwdata_d = '0;
                  endcase
               end else if ((Opcode == OP_JAL) || alu_write) begin
                  state_d = ST_WRITE;
                  wdata_d = (Opcode == OP_JAL) ? Pc4 : AluResult;
                  wadr_d  = DstAdr;
                  wen_d   = (DstAdr != '0);
               end
            end
         end
         ST_MEM_WAIT: begin
            if (mem.MemAck) begin
               if (we_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WRITE;
                  wdata_d = load_data;
               end
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         lane_q      <= '0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         mwdata_q    <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         wadr_q      <= '0;
         wen_q       <= 1'b0;
         align_exc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         lane_q      <= lane_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         mwdata_q    <= mwdata_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         wadr_q      <= wadr_d;
         wen_q       <= wen_d;
         align_exc_q <= align_exc_d;
      end
   end

   // Request is decoded straight from state so reset drops it without a clock.
   assign mem.MemReq   = (state_q == ST_MEM_WAIT);
   assign mem.MemWe    = we_q;
   assign mem.MemAdr   = adr_q;
   assign mem.MemWdata = mwdata_q;
   assign mem.MemBe    = be_q;
   assign InReady      = (state_q == ST_IDLE);
   assign Wen          = (state_q == ST_WRITE) && wen_q;
   assign Wdata        = wdata_q;
   assign Wadr         = wadr_q;
   assign AlignExc     = align_exc_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-cycle instructions
// plus hand-written load/store, reset-abort and stray-ack sequences.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [5:0]  Opcode = '0;
   logic [5:0]  Funct = '0;
   logic [4:0]  DstAdr = '0;
   logic [31:0] AluResult = '0;
   logic [31:0] StoreData = '0;
   logic [31:0] Pc4 = '0;
   logic [31:0] Wdata;
   logic [4:0]  Wadr;
   logic        Wen;
   logic        AlignExc;

   int checks = 0;
   int errors = 0;

   wb_stage_if mem ();

   wb_stage dut (
      .CLK       (CLK),
      .RST       (RST),
      .InValid   (InValid),
      .InReady   (InReady),
      .Opcode    (Opcode),
      .Funct     (Funct),
      .DstAdr    (DstAdr),
      .AluResult (AluResult),
      .StoreData (StoreData),
      .Pc4       (Pc4),
      .mem       (mem),
      .Wdata     (Wdata),
      .Wadr      (Wadr),
      .Wen       (Wen),
      .AlignExc  (AlignExc)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  dst;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic        exp_wen;
      logic [4:0]  exp_wadr;
      logic [31:0] exp_wdata;
      logic        exp_align;
      logic        exp_ready;
   } vec_t;

   vec_t vecs [9];

   task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
      Opcode = op; Funct = fn; DstAdr = dst; AluResult = alu; StoreData = sd; Pc4 = pc4;
      InValid = 1'b1;
      @(posedge CLK); #1;
      // Scramble inputs after accept; the stage must not look at them again.
      InValid = 1'b0;
      AluResult = ~alu; StoreData = ~sd; Pc4 = ~pc4; DstAdr = ~dst; Opcode = 6'h3F;
   endtask

   task automatic mem_txn(input string name, input logic [5:0] op, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] dst, input logic [31:0] rdata,
                          input int delay, input logic [3:0] exp_be, input logic [31:0] exp_adr,
                          input logic [31:0] exp_mwd, input logic exp_we, input logic exp_wen,
                          input logic [31:0] exp_wd);
      present(op, 6'h00, dst, alu, sd, 32'h0);
      for (int i = 1; i <= delay; i++) begin
         @(negedge CLK);
         check({name, " MemReq"}, {31'd0, mem.MemReq}, 32'd1);
         check({name, " MemAdr"}, mem.MemAdr, exp_adr);
         check({name, " MemBe"}, {28'd0, mem.MemBe}, {28'd0, exp_be});
         check({name, " MemWe"}, {31'd0, mem.MemWe}, {31'd0, exp_we});
         if (exp_we) check({name, " MemWdata"}, mem.MemWdata, exp_mwd);
         check({name, " Wen wait"}, {31'd0, Wen}, 32'd0);
         check({name, " InReady wait"}, {31'd0, InReady}, 32'd0);
         if (i == delay) begin
            mem.MemAck = 1'b1;
            mem.MemRdata = rdata;
         end
         @(posedge CLK); #1;
         mem.MemAck = 1'b0;
         mem.MemRdata = 32'hDEAD_BEEF;
      end
      @(negedge CLK);
      check({name, " MemReq drop"}, {31'd0, mem.MemReq}, 32'd0);
      check({name, " Wen"}, {31'd0, Wen}, {31'd0, exp_wen});
      check({name, " InReady after ack"}, {31'd0, InReady}, {31'd0, exp_we});
      if (exp_wen) begin
         check({name, " Wdata"}, Wdata, exp_wd);
         check({name, " Wadr"}, {27'd0, Wadr}, {27'd0, dst});
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      check({name, " Wen end"}, {31'd0, Wen}, 32'd0);
      check({name, " InReady end"}, {31'd0, InReady}, 32'd1);
      @(posedge CLK); #1;
   endtask

   initial begin
      mem.MemAck = 1'b0;
      mem.MemRdata = '0;
      //             op     fn     dst    alu           pc4           wen  wadr   wdata         align ready
      vecs[0] = '{6'h00, 6'h21, 5'd5,  32'h0000_1234, 32'h0,        1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0};
      vecs[1] = '{OP_JAL, 6'h00, 5'd31, 32'h1111_0000, 32'h0040_0008, 1'b1, 5'd31, 32'h0040_0008, 1'b0, 1'b0};
      vecs[2] = '{6'h00, 6'h21, 5'd0,  32'h0000_5555, 32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
      vecs[3] = '{6'h09, 6'h3F, 5'd12, 32'hCAFE_0001, 32'h0,        1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 1'b0};
      vecs[4] = '{6'h00, FN_JR, 5'd7,  32'h0000_7777, 32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
      vecs[5] = '{6'h3E, 6'h00, 5'd9,  32'h0000_9999, 32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
      vecs[6] = '{OP_LW, 6'h00, 5'd3,  32'h0000_0006, 32'h0,        1'b0, 5'd0,  32'h0,         1'b1, 1'b1};
      vecs[7] = '{OP_LHU, 6'h00, 5'd3, 32'h0000_0101, 32'h0,        1'b0, 5'd0,  32'h0,         1'b1, 1'b1};
      vecs[8] = '{OP_SW, 6'h00, 5'd0,  32'h0000_0042, 32'h0,        1'b0, 5'd0,  32'h0,         1'b1, 1'b1};

      #12;
      check("reset Wen", {31'd0, Wen}, 32'd0);
      check("reset Wdata", Wdata, 32'd0);
      check("reset MemReq", {31'd0, mem.MemReq}, 32'd0);
      check("reset AlignExc", {31'd0, AlignExc}, 32'd0);
      check("reset InReady", {31'd0, InReady}, 32'd1);
      @(negedge CLK); RST = 1'b0;
      @(posedge CLK); #1;

      foreach (vecs[i]) begin
         present(vecs[i].op, vecs[i].fn, vecs[i].dst, vecs[i].alu, 32'h0, vecs[i].pc4);
         @(negedge CLK);
         check($sformatf("vec%0d Wen", i), {31'd0, Wen}, {31'd0, vecs[i].exp_wen});
         if (vecs[i].exp_wen) begin
            check($sformatf("vec%0d Wadr", i), {27'd0, Wadr}, {27'd0, vecs[i].exp_wadr});
            check($sformatf("vec%0d Wdata", i), Wdata, vecs[i].exp_wdata);
         end
         check($sformatf("vec%0d AlignExc", i), {31'd0, AlignExc}, {31'd0, vecs[i].exp_align});
         check($sformatf("vec%0d InReady", i), {31'd0, InReady}, {31'd0, vecs[i].exp_ready});
         check($sformatf("vec%0d MemReq", i), {31'd0, mem.MemReq}, 32'd0);
         @(posedge CLK); #1;
         @(negedge CLK);
         check($sformatf("vec%0d Wen end", i), {31'd0, Wen}, 32'd0);
         check($sformatf("vec%0d AlignExc end", i), {31'd0, AlignExc}, 32'd0);
         check($sformatf("vec%0d InReady end", i), {31'd0, InReady}, 32'd1);
         $display("vec%0d op=%02h alu=%08h -> Wen=%0b Wadr=%0d Wdata=%08h", i, vecs[i].op,
                  vecs[i].alu, vecs[i].exp_wen, vecs[i].exp_wadr, vecs[i].exp_wdata);
         @(posedge CLK); #1;
      end

      //      name   op      alu            sd             dst   rdata          dly be       adr            mwdata         we    wen   wdata
      mem_txn("LB",  OP_LB,  32'h0000_0103, 32'h0,         5'd4, 32'h8077_6655, 3, 4'b1111, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hFFFF_FF80);
      $display("LB  addr=00000103 -> Wdata=FFFFFF80");
      mem_txn("LBU", OP_LBU, 32'h0000_0103, 32'h0,         5'd4, 32'h8077_6655, 3, 4'b1111, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'h0000_0080);
      $display("LBU addr=00000103 -> Wdata=00000080");
      mem_txn("LH",  OP_LH,  32'h0000_0102, 32'h0,         5'd6, 32'h8077_6655, 1, 4'b1111, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hFFFF_8077);
      $display("LH  addr=00000102 -> Wdata=FFFF8077");
      mem_txn("LHU", OP_LHU, 32'h0000_0100, 32'h0,         5'd6, 32'h8077_E655, 2, 4'b1111, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'h0000_E655);
      $display("LHU addr=00000100 -> Wdata=0000E655");
      mem_txn("LW",  OP_LW,  32'h0000_0008, 32'h0,         5'd8, 32'h1234_5678, 2, 4'b1111, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h1234_5678);
      $display("LW  addr=00000008 -> Wdata=12345678");
      mem_txn("LW r0", OP_LW, 32'h0000_0008, 32'h0,        5'd0, 32'h1234_5678, 1, 4'b1111, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 32'h0);
      $display("LW  r0 -> no Wen");
      mem_txn("SH",  OP_SH,  32'h0000_0012, 32'hABCD_BEEF, 5'd9, 32'h0,         2, 4'b1100, 32'h0000_0010, 32'hBEEF_BEEF, 1'b1, 1'b0, 32'h0);
      $display("SH  addr=00000012 -> MemBe=1100 MemWdata=BEEFBEEF");
      mem_txn("SB",  OP_SB,  32'h0000_0021, 32'h1234_565A, 5'd9, 32'h0,         1, 4'b0010, 32'h0000_0020, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0);
      $display("SB  addr=00000021 -> MemBe=0010 MemWdata=5A5A5A5A");
      mem_txn("SW",  OP_SW,  32'h0000_0040, 32'hC0DE_F00D, 5'd9, 32'h0,         2, 4'b1111, 32'h0000_0040, 32'hC0DE_F00D, 1'b1, 1'b0, 32'h0);
      $display("SW  addr=00000040 -> MemBe=1111 MemWdata=C0DEF00D");

      // Stray ack while idle must not start anything.
      mem.MemAck = 1'b1; mem.MemRdata = 32'h0BAD_0BAD;
      @(posedge CLK); #1;
      mem.MemAck = 1'b0;
      @(negedge CLK);
      check("idle ack Wen", {31'd0, Wen}, 32'd0);
      check("idle ack MemReq", {31'd0, mem.MemReq}, 32'd0);
      check("idle ack InReady", {31'd0, InReady}, 32'd1);
      $display("stray MemAck in IDLE -> ignored");
      @(posedge CLK); #1;

      // Reset in the middle of a load abandons it; a late ack is ignored.
      present(OP_LW, 6'h00, 5'd10, 32'h0000_0020, 32'h0, 32'h0);
      @(negedge CLK);
      check("rst MemReq before", {31'd0, mem.MemReq}, 32'd1);
      RST = 1'b1;
      #1;
      check("rst MemReq async", {31'd0, mem.MemReq}, 32'd0);
      check("rst InReady async", {31'd0, InReady}, 32'd1);
      @(posedge CLK); #1;
      @(negedge CLK); RST = 1'b0;
      mem.MemAck = 1'b1; mem.MemRdata = 32'h7777_7777;
      @(posedge CLK); #1;
      mem.MemAck = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("late ack Wen", {31'd0, Wen}, 32'd0);
         check("late ack MemReq", {31'd0, mem.MemReq}, 32'd0);
         check("late ack InReady", {31'd0, InReady}, 32'd1);
      end
      $display("RST in MEM_WAIT -> MemReq dropped, late ack ignored");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
